// File: rtl/switch_debounce4_if.sv
// Switch-side bundle: raw levels in, debounced levels and status out.
interface switch_debounce4_if;
  logic [3:0] SW_raw;
  logic [3:0] SW_clean;
  logic       changed;
  logic       settling;
  logic [7:0] change_count;

  modport master (output SW_raw, input SW_clean, changed, settling, change_count);
  modport slave  (input SW_raw, output SW_clean, changed, settling, change_count);
endinterface

// File: rtl/switch_debounce4.sv
// Two-flop synchronizer plus word-wide debounce FSM for four slide switches.
// SW_clean only moves after STABLE_CYCLES identical synchronized samples.
module switch_debounce4 #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  switch_debounce4_if.slave sw
);
  localparam int          NUM_SW = 4;
  localparam logic [15:0] LAST   = 16'(STABLE_CYCLES - 1);

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t              state_q, state_d;
  logic [NUM_SW-1:0]   sync1, sync2, cand, clean;
  logic [15:0]         cnt;
  logic [7:0]          count;
  logic                changed_q;
  logic                load, commit, clr, inc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw.SW_raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // The whole 4-bit word is one candidate, so a partial mix never commits.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    commit  = 1'b0;
    clr     = 1'b0;
    inc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2 != clean) begin
          load    = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (sync2 == clean) begin
          clr     = 1'b1;
          state_d = IDLE;
        end else if (sync2 != cand) begin
          load = 1'b1;
        end else if (cnt == LAST) begin
          commit  = 1'b1;
          clr     = 1'b1;
          state_d = IDLE;
        end else begin
          inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand      <= '0;
      cnt       <= '0;
      clean     <= '0;
      count     <= '0;
      changed_q <= 1'b0;
    end else begin
      if (load) begin
        cand <= sync2;
        cnt  <= 16'd1;
      end else if (clr) begin
        cnt <= '0;
      end else if (inc) begin
        cnt <= cnt + 16'd1;
      end
      if (commit) begin
        clean <= cand;
        count <= count + 8'd1;
      end
      changed_q <= commit;
    end
  end

  always_comb begin
    sw.SW_clean     = clean;
    sw.changed      = changed_q;
    sw.settling     = (state_q == SETTLE);
    sw.change_count = count;
  end
endmodule
